// File: rtl/sr_flipflop_pkg.sv
// Shared constants and next-state helper for the sr_flipflop bank.
// Forbidden-state policy encodings and the width of the optional forbid counter.
package sr_flipflop_pkg;

    localparam int POLICY_HOLD  = 0;
    localparam int POLICY_SET   = 1;
    localparam int POLICY_RESET = 2;

    localparam int FORBID_CNT_W = 8;

    // Q value chosen on an S=R=1 edge; unknown policy codes fall back to hold.
    function automatic logic policy_q(input int policy, input logic q);
        case (policy)
            POLICY_SET:   return 1'b1;
            POLICY_RESET: return 1'b0;
            default:      return q;
        endcase
    endfunction

endpackage

// File: rtl/sr_flipflop_sr_cell.sv
// Single-bit clocked SR register with a configurable S=R=1 policy.
// Qbar is derived from the Q flop so the two can never disagree.
module sr_cell
    import sr_flipflop_pkg::*;
#(
    parameter int   FORBID_POLICY = POLICY_HOLD,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic s_i,
    input  logic r_i,
    output logic q_o,
    output logic qbar_o,
    output logic forbid_o
);

    logic q_d;
    logic q_q;
    logic forbid_d;
    logic forbid_q;

    // Next-state decode; an unknown S/R pair holds the stored value.
    always_comb begin
        q_d      = q_q;
        forbid_d = s_i & r_i;
        case ({s_i, r_i})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11:   q_d = policy_q(FORBID_POLICY, q_q);
            default: q_d = q_q;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            q_q      <= RESET_VAL;
            forbid_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            forbid_q <= forbid_d;
        end
    end

    assign q_o      = q_q;
    assign qbar_o   = ~q_q;
    assign forbid_o = forbid_q;

endmodule

// File: rtl/sr_flipflop.sv
// Bank of WIDTH independent clocked SR bits with per-bit forbid flags.
// Define SR_FORBID_CNT_EN to add the saturating FORBID_CNT edge counter.
module sr_flipflop
    import sr_flipflop_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}},
    parameter int               FORBID_POLICY = POLICY_HOLD
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [WIDTH-1:0]        S,
    input  logic [WIDTH-1:0]        R,
    output logic [WIDTH-1:0]        Q,
    output logic [WIDTH-1:0]        Qbar,
`ifdef SR_FORBID_CNT_EN
    output logic [FORBID_CNT_W-1:0] FORBID_CNT,
`endif
    output logic [WIDTH-1:0]        FORBID
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .FORBID_POLICY (FORBID_POLICY),
            .RESET_VAL     (RESET_VAL[i])
        ) u_cell (
            .clk_i    (CLK),
            .rst_n_i  (RST_N),
            .s_i      (S[i]),
            .r_i      (R[i]),
            .q_o      (Q[i]),
            .qbar_o   (Qbar[i]),
            .forbid_o (FORBID[i])
        );
    end

`ifdef SR_FORBID_CNT_EN
    localparam logic [FORBID_CNT_W-1:0] CNT_MAX = {FORBID_CNT_W{1'b1}};
    localparam logic [FORBID_CNT_W-1:0] CNT_ONE = {{(FORBID_CNT_W-1){1'b0}}, 1'b1};

    logic [FORBID_CNT_W-1:0] cnt_d;
    logic [FORBID_CNT_W-1:0] cnt_q;

    // One step per edge with any forbidden bit, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if ((|(S & R)) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= {FORBID_CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign FORBID_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_sr_flipflop.sv
// Scoreboard bench: three 4-bit banks (hold / set-dominant / reset-dominant policies)
// driven with identical S/R; expected values come from a bench-side reference model.
module tb_sr_flipflop;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q [3];
        logic [W-1:0] f;
        logic [7:0]   cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] s_in = 4'b0000;
    logic [W-1:0] r_in = 4'b0000;

    logic [W-1:0] q   [3];
    logic [W-1:0] qb  [3];
    logic [W-1:0] fb  [3];
`ifdef SR_FORBID_CNT_EN
    logic [7:0]   cnt [3];
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq [3];
    logic [7:0]   mcnt = 8'd0;
    exp_t         sb [$];

    always #5 clk = ~clk;

    sr_flipflop #(.WIDTH(W), .RESET_VAL(4'b0000), .FORBID_POLICY(0)) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .S(s_in), .R(r_in),
        .Q(q[0]), .Qbar(qb[0]),
`ifdef SR_FORBID_CNT_EN
        .FORBID_CNT(cnt[0]),
`endif
        .FORBID(fb[0]));

    sr_flipflop #(.WIDTH(W), .RESET_VAL(4'b1010), .FORBID_POLICY(1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .S(s_in), .R(r_in),
        .Q(q[1]), .Qbar(qb[1]),
`ifdef SR_FORBID_CNT_EN
        .FORBID_CNT(cnt[1]),
`endif
        .FORBID(fb[1]));

    sr_flipflop #(.WIDTH(W), .RESET_VAL(4'b0000), .FORBID_POLICY(2)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .S(s_in), .R(r_in),
        .Q(q[2]), .Qbar(qb[2]),
`ifdef SR_FORBID_CNT_EN
        .FORBID_CNT(cnt[2]),
`endif
        .FORBID(fb[2]));

    function automatic int pol_of(input int p);
        return p;
    endfunction

    function automatic logic [W-1:0] rv_of(input int p);
        return (p == 1) ? 4'b1010 : 4'b0000;
    endfunction

    // Reference next state, written as sum-of-products over the truth table.
    function automatic logic [W-1:0] model_next(input int pol, input logic [W-1:0] qv,
                                                input logic [W-1:0] s, input logic [W-1:0] r);
        logic [W-1:0] both_val;
        both_val = (pol == 1) ? 4'b1111 : ((pol == 2) ? 4'b0000 : qv);
        return (s & ~r) | (~s & ~r & qv) | (s & r & both_val);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic [W-1:0] s, input logic [W-1:0] r);
        exp_t e;
        @(negedge clk);
        rst_n = rn;
        s_in  = s;
        r_in  = r;
        for (int p = 0; p < 3; p++) begin
            mq[p] = rn ? model_next(pol_of(p), mq[p], s, r) : rv_of(p);
            e.q[p] = mq[p];
        end
        e.f = rn ? (s & r) : 4'b0000;
        if (!rn)
            mcnt = 8'd0;
        else if ((|(s & r)) && (mcnt != 8'd255))
            mcnt = mcnt + 8'd1;
        e.cnt = mcnt;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        for (int p = 0; p < 3; p++) begin
            check_eq($sformatf("q%0d", p),    {28'd0, q[p]},  {28'd0, e.q[p]});
            check_eq($sformatf("qbar%0d", p), {28'd0, qb[p]}, {28'd0, ~e.q[p]});
            check_eq($sformatf("forbid%0d", p), {28'd0, fb[p]}, {28'd0, e.f});
`ifdef SR_FORBID_CNT_EN
            check_eq($sformatf("cnt%0d", p), {24'd0, cnt[p]}, {24'd0, e.cnt});
`endif
        end
    endtask

    initial begin
        for (int p = 0; p < 3; p++) mq[p] = rv_of(p);

        drive(1'b0, 4'b1111, 4'b0000);   // reset ignores S
        drive(1'b1, 4'b1111, 4'b0000);   // set
        drive(1'b1, 4'b0000, 4'b0000);   // hold high
        drive(1'b1, 4'b0000, 4'b1111);   // clear
        drive(1'b1, 4'b0000, 4'b0000);   // hold low
        drive(1'b1, 4'b1111, 4'b0000);   // set again
        drive(1'b1, 4'b1111, 4'b1111);   // forbidden from Q=1
        drive(1'b1, 4'b0000, 4'b0000);   // flag drops
        drive(1'b0, 4'b0000, 4'b0000);
        drive(1'b1, 4'b0101, 4'b0011);   // per-bit independence
        drive(1'b1, 4'b1111, 4'b1111);   // forbidden from mixed state
        drive(1'b0, 4'b1111, 4'b1111);   // reset overrides forbidden
        drive(1'b1, 4'b1100, 4'b1010);

        for (int i = 0; i < 80; i++) begin
            drive(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

`ifdef SR_FORBID_CNT_EN
        drive(1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 4'b0001 << (i % 4), 4'b0001 << (i % 4));
        end
        drive(1'b0, 4'b0000, 4'b0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_flipflop.md
Name: sr_flipflop

Overview:
- Clocked set/reset storage element, parameterisable as a bank of WIDTH independent SR bits.
- Each bit has registered true (Q) and complement (Qbar) outputs.
- A registered per-bit flag reports the forbidden S=R=1 condition.
- Used as a generic status/flag holding register: set by one event, cleared by another.

Parameters:
- WIDTH, 1, number of independent SR bits (1..32).
- RESET_VAL, 0 (WIDTH bits), value loaded into Q on reset.
- FORBID_POLICY, 0, next-state action when S=R=1 on a bit: 0 = hold, 1 = set-dominant, 2 = reset-dominant; any other value is treated as 0.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- S  input  WIDTH  per-bit set request.
- R  input  WIDTH  per-bit reset request.
- Q  output  WIDTH  registered stored value.
- Qbar  output  WIDTH  complement of Q.
- FORBID  output  WIDTH  per-bit flag: 1 when that bit sampled S=R=1 at the last edge.

Behaviour:
- Interface: one clock (CLK); reset RST_N is synchronous and active-low.
- All outputs are registered. Latency is one cycle: values sampled at rising edge k appear on Q/Qbar/FORBID after edge k.
- Reset: on a rising edge with RST_N=0:
  - Q <= RESET_VAL, Qbar <= ~RESET_VAL, FORBID <= 0.
  - Reset overrides S and R unconditionally.
- Per bit i, on a rising edge with RST_N=1:
  - S=0, R=0: Q holds.
  - S=1, R=0: Q <= 1.
  - S=0, R=1: Q <= 0.
  - S=1, R=1: Q follows FORBID_POLICY (hold / 1 / 0).
  - FORBID[i] <= S[i]&R[i] on every non-reset edge, so the flag is high for exactly one cycle per forbidden sample.
- Invariants:
  - Qbar is always exactly ~Q, bitwise, every cycle including reset and forbidden cases.
  - Q and Qbar are never equal.
  - Bits are fully independent; no cross-bit interaction.
- Between rising edges, S/R changes have no effect (edge-triggered, not level-sensitive).
- Reset mid-operation discards any pending S/R. The first non-reset edge after RST_N rises evaluates S/R normally.
- X on S/R must not propagate to Qbar as anything other than ~Q (no separate Qbar state).

Optional Feature:
- Macro: SR_FORBID_CNT_EN.
- Defined:
  - Adds output FORBID_CNT (8 bits): count of non-reset edges on which any bit had S=R=1.
  - Saturates at 255; cleared to 0 on reset.
  - Increments by at most 1 per edge, regardless of how many bits are forbidden.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sr_flipflop_pkg holds:
  - policy constants POLICY_HOLD=0, POLICY_SET=1, POLICY_RESET=2;
  - FORBID_CNT_W=8.
- One natural sub-module, sr_cell: a single-bit SR register with policy, Q/Qbar/forbid outputs.
  - Instantiated WIDTH times via generate.
  - The optional counter lives in the top level.

Test Plan:
- Reset: RST_N=0, S=1, R=0 for one edge -> Q=0, Qbar=1, FORBID=0 (RESET_VAL=0); S ignored.
- Set then hold: RST_N=1; edge with S=1,R=0 -> Q=1, Qbar=0; next edge S=0,R=0 -> Q=1, Qbar=0.
- Clear then hold: edge with S=0,R=1 -> Q=0, Qbar=1; next edge S=0,R=0 -> Q stays 0.
- Forbidden per policy, from Q=1:
  - S=1,R=1 edge -> FORBID=1 for one cycle.
  - Q=1 for policy 0, Q=1 for policy 1, Q=0 for policy 2.
  - Next edge S=R=0 -> FORBID=0.
- Multi-bit independence: WIDTH=4, S=4'b0101, R=4'b0011 from Q=0000 -> Q=4'b0100, Qbar=4'b1011, FORBID=4'b0001 (policy 0).
- Optional counter (SR_FORBID_CNT_EN): 300 consecutive forbidden edges -> FORBID_CNT=255; then RST_N=0 for one edge -> FORBID_CNT=0.
